// File: rtl/burst_replay_buffer_if.sv
// Sample-burst handshake bundle: input capture side plus valid/ready replay side.
interface burst_replay_buffer_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/burst_replay_buffer.sv
// Capture one contiguous in_valid burst into memory, then replay it over valid/ready.
// Define BURST_REPLAY_REVERSE_EN to replay in LIFO order instead of FIFO order.
//   state   | meaning
//   S_IDLE  | waiting for the first word of a burst
//   S_LOAD  | storing burst words, overflow words dropped
//   S_DRAIN | replaying stored words through read and output stages
module burst_replay_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  burst_replay_buffer_if.slave bus,
  output logic                 busy,
  output logic [ADDR_W:0]      count,
  output logic                 drop
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   tx_cnt_q, tx_cnt_d;
  logic              drop_q, drop_d;
  logic              rvld_q, rvld_d;
  logic              ovld_q, ovld_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              wr_en, rd_en, adv, xfer;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    drop_d   = drop_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    wr_en    = 1'b0;
    wr_addr  = count_q[ADDR_W-1:0];
    xfer     = ovld_q & bus.out_ready;
    // read register advances into the output register when that one is empty or emptying
    adv      = rvld_q & (~ovld_q | xfer);
    rd_en    = (state_q == S_DRAIN) && (rd_cnt_q != count_q) && (~rvld_q || adv);
`ifdef BURST_REPLAY_REVERSE_EN
    rd_addr  = count_q[ADDR_W-1:0] - ADDR_W'(1) - rd_cnt_q[ADDR_W-1:0];
`else
    rd_addr  = rd_cnt_q[ADDR_W-1:0];
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          count_d  = ONE;
          drop_d   = 1'b0;
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + ONE;
          end else begin
            drop_d  = 1'b1;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.in_valid) drop_d = 1'b1;
        if (rd_en) rd_cnt_d = rd_cnt_q + ONE;
        if (xfer) begin
          tx_cnt_d = tx_cnt_q + ONE;
          if (tx_cnt_q == count_q - ONE) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rvld_d  = rd_en | (rvld_q & ~adv);
    ovld_d  = adv | (ovld_q & ~xfer);
    odata_d = adv ? rdata_q : ((ovld_q & ~xfer) ? odata_q : '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.in_data;
    if (rd_en) rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      drop_q   <= 1'b0;
      rvld_q   <= 1'b0;
      ovld_q   <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      drop_q   <= drop_d;
      rvld_q   <= rvld_d;
      ovld_q   <= ovld_d;
      odata_q  <= odata_d;
    end
  end

  assign busy          = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign count         = count_q;
  assign drop          = drop_q;
  assign bus.out_valid = ovld_q;
  assign bus.out_data  = odata_q;
endmodule
